// File: rtl/id_ex_stage_pkg.sv
// Shared decode/execute definitions: control bundle layout, fixed register
// numbers and the ALU op codes the decoder and execute stage agree on.
package id_ex_stage_pkg;

  localparam int RA_REG   = 31;
  localparam int ZERO_REG = 0;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       we_reg;
    logic       alu_src_imm;
    logic       we_dm;
    logic [2:0] alu_op;
    logic       wr_ra_jal;
    logic       wr_ra_instr;
    logic       jal_wd_sel;
    logic       dm_load_op;
    logic       r_type;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: the decode-slot instruction reads a register
// that the load currently in EX has not yet produced.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          valid_d,
  input  logic          jump_d,
  input  logic          branch_d,
  input  logic          we_dm_d,
  input  logic          r_type_d,
  input  logic [RW-1:0] rs_d,
  input  logic [RW-1:0] rt_d,
  input  logic          valid_e,
  input  logic          dm_load_op_e,
  input  logic          we_reg_e,
  input  logic [RW-1:0] wa_e,
  output logic          load_use
);

  logic uses_rs;
  logic uses_rt;
  logic load_in_ex;

  // Stores read rt as write data and branches compare rs with rt.
  assign uses_rs = valid_d & ~jump_d;
  assign uses_rt = valid_d & (r_type_d | branch_d | we_dm_d);

  // A load targeting $0 produces nothing a consumer could wait for.
  assign load_in_ex = valid_e & dm_load_op_e & we_reg_e & (wa_e != RW'(ZERO_REG));

  assign load_use = load_in_ex & ((uses_rs & (rs_d == wa_e)) |
                                  (uses_rt & (rt_d == wa_e)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction, resolves its
// destination, inserts bubbles on load-use/flush and counts load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic             we_reg_d,
  input  logic             alu_src_imm_d,
  input  logic             we_dm_d,
  input  logic             wr_ra_jal_d,
  input  logic             wr_ra_instr_d,
  input  logic             jal_wd_sel_d,
  input  logic             dm_load_op_d,
  input  logic             r_type_d,
  input  logic [2:0]       alu_op_d,
  input  logic [DW-1:0]    pc_plus4_d,
  input  logic [DW-1:0]    rd1_d,
  input  logic [DW-1:0]    rd2_d,
  input  logic [DW-1:0]    imm_d,
  input  logic [RW-1:0]    rs_d,
  input  logic [RW-1:0]    rt_d,
  input  logic [RW-1:0]    rd_d,
  input  logic             flush_e,
  input  logic             hold_e,
  output logic             stall_fd,
  output logic             valid_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             we_reg_e,
  output logic             alu_src_imm_e,
  output logic             we_dm_e,
  output logic             wr_ra_jal_e,
  output logic             wr_ra_instr_e,
  output logic             jal_wd_sel_e,
  output logic             dm_load_op_e,
  output logic             r_type_e,
  output logic [2:0]       alu_op_e,
  output logic [DW-1:0]    pc_plus4_e,
  output logic [DW-1:0]    rd1_e,
  output logic [DW-1:0]    rd2_e,
  output logic [DW-1:0]    imm_e,
  output logic [RW-1:0]    rs_e,
  output logic [RW-1:0]    rt_e,
  output logic [RW-1:0]    wa_e,
  output logic [CNT_W-1:0] bubble_cnt
);

  ctrl_t         ctrl_d;
  ctrl_t         ctrl_q;
  logic [RW-1:0] wa_d;
  logic          load_use;
  logic          insert_bubble;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl_d             = '0;
    ctrl_d.branch      = branch_d;
    ctrl_d.jump        = jump_d;
    ctrl_d.we_reg      = we_reg_d & valid_d;
    ctrl_d.alu_src_imm = alu_src_imm_d;
    ctrl_d.we_dm       = we_dm_d & valid_d;
    ctrl_d.alu_op      = alu_op_d;
    ctrl_d.wr_ra_jal   = wr_ra_jal_d;
    ctrl_d.wr_ra_instr = wr_ra_instr_d;
    ctrl_d.jal_wd_sel  = jal_wd_sel_d;
    ctrl_d.dm_load_op  = dm_load_op_d;
    ctrl_d.r_type      = r_type_d;

    wa_d = rt_d;
    if (jump_d && wr_ra_jal_d) wa_d = RW'(RA_REG);
    else if (r_type_d)         wa_d = rd_d;
  end

  id_ex_stage_hazard_detect #(.RW(RW)) u_hazard (
    .valid_d      (valid_d),
    .jump_d       (jump_d),
    .branch_d     (branch_d),
    .we_dm_d      (we_dm_d),
    .r_type_d     (r_type_d),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .valid_e      (valid_e),
    .dm_load_op_e (ctrl_q.dm_load_op),
    .we_reg_e     (ctrl_q.we_reg),
    .wa_e         (wa_e),
    .load_use     (load_use)
  );

  // A flush already empties the decode slot, so it must not also stall it.
  assign stall_fd      = (load_use & ~flush_e) | hold_e;
  assign insert_bubble = flush_e | (~hold_e & load_use);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n || insert_bubble) begin
      valid_e    <= 1'b0;
      ctrl_q     <= '0;
      pc_plus4_e <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      wa_e       <= '0;
    end else if (!hold_e) begin
      valid_e    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_plus4_e <= pc_plus4_d;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      imm_e      <= imm_d;
      rs_e       <= rs_d;
      rt_e       <= rt_d;
      wa_e       <= wa_d;
    end
  end

  // Only load-use bubbles are counted; flush bubbles belong to branch resolution.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!flush_e && !hold_e && load_use && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign branch_e      = ctrl_q.branch;
  assign jump_e        = ctrl_q.jump;
  assign we_reg_e      = ctrl_q.we_reg;
  assign alu_src_imm_e = ctrl_q.alu_src_imm;
  assign we_dm_e       = ctrl_q.we_dm;
  assign wr_ra_jal_e   = ctrl_q.wr_ra_jal;
  assign wr_ra_instr_e = ctrl_q.wr_ra_instr;
  assign jal_wd_sel_e  = ctrl_q.jal_wd_sel;
  assign dm_load_op_e  = ctrl_q.dm_load_op;
  assign r_type_e      = ctrl_q.r_type;
  assign alu_op_e      = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model checked every
// cycle, plus literal expectations on the key scenarios.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW      = 32;
  localparam int RW      = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic valid, branch, jump, we_reg, alu_src_imm, we_dm;
    logic wr_ra_jal, wr_ra_instr, jal_wd_sel, dm_load_op, r_type;
    logic [2:0]    alu_op;
    logic [DW-1:0] pc, rd1, rd2, imm;
    logic [RW-1:0] rs, rt, rd;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n, flush_e, hold_e;
  logic valid_d, branch_d, jump_d, we_reg_d, alu_src_imm_d, we_dm_d;
  logic wr_ra_jal_d, wr_ra_instr_d, jal_wd_sel_d, dm_load_op_d, r_type_d;
  logic [2:0] alu_op_d;
  logic [DW-1:0] pc_plus4_d, rd1_d, rd2_d, imm_d;
  logic [RW-1:0] rs_d, rt_d, rd_d;
  logic stall_fd, valid_e, branch_e, jump_e, we_reg_e, alu_src_imm_e, we_dm_e;
  logic wr_ra_jal_e, wr_ra_instr_e, jal_wd_sel_e, dm_load_op_e, r_type_e;
  logic [2:0] alu_op_e;
  logic [DW-1:0] pc_plus4_e, rd1_e, rd2_e, imm_e;
  logic [RW-1:0] rs_e, rt_e, wa_e;
  logic [CNT_W-1:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RW(RW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
    .branch_d(branch_d), .jump_d(jump_d), .we_reg_d(we_reg_d),
    .alu_src_imm_d(alu_src_imm_d), .we_dm_d(we_dm_d), .wr_ra_jal_d(wr_ra_jal_d),
    .wr_ra_instr_d(wr_ra_instr_d), .jal_wd_sel_d(jal_wd_sel_d),
    .dm_load_op_d(dm_load_op_d), .r_type_d(r_type_d), .alu_op_d(alu_op_d),
    .pc_plus4_d(pc_plus4_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .flush_e(flush_e), .hold_e(hold_e),
    .stall_fd(stall_fd), .valid_e(valid_e), .branch_e(branch_e), .jump_e(jump_e),
    .we_reg_e(we_reg_e), .alu_src_imm_e(alu_src_imm_e), .we_dm_e(we_dm_e),
    .wr_ra_jal_e(wr_ra_jal_e), .wr_ra_instr_e(wr_ra_instr_e),
    .jal_wd_sel_e(jal_wd_sel_e), .dm_load_op_e(dm_load_op_e), .r_type_e(r_type_e),
    .alu_op_e(alu_op_e), .pc_plus4_e(pc_plus4_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .rs_e(rs_e), .rt_e(rt_e), .wa_e(wa_e), .bubble_cnt(bubble_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic instr_t base(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                  input logic [RW-1:0] rd);
    instr_t i;
    i       = '0;
    i.valid = 1'b1;
    i.rs    = rs;
    i.rt    = rt;
    i.rd    = rd;
    i.pc    = 32'h0040_0004 + {15'd0, rs, rt, rd, 2'b00};
    i.rd1   = 32'h1000_0000 | {27'd0, rs};
    i.rd2   = 32'h2000_0000 | {27'd0, rt};
    i.imm   = 32'hFFFF_FF00 | {27'd0, rd};
    return i;
  endfunction

  function automatic instr_t mk_r(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                  input logic [RW-1:0] rd, input logic [2:0] op);
    instr_t i = base(rs, rt, rd);
    i.we_reg = 1'b1; i.r_type = 1'b1; i.alu_op = op;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    instr_t i = base(rs, rt, 5'd0);
    i.we_reg = 1'b1; i.dm_load_op = 1'b1; i.alu_src_imm = 1'b1; i.alu_op = ALU_ADD;
    return i;
  endfunction

  function automatic instr_t mk_addi(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    instr_t i = base(rs, rt, 5'd0);
    i.we_reg = 1'b1; i.alu_src_imm = 1'b1; i.alu_op = ALU_ADD;
    return i;
  endfunction

  function automatic instr_t mk_sw(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    instr_t i = base(rs, rt, 5'd0);
    i.we_dm = 1'b1; i.alu_src_imm = 1'b1; i.alu_op = ALU_ADD;
    return i;
  endfunction

  function automatic instr_t mk_jal(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                    input logic [RW-1:0] rd);
    instr_t i = base(rs, rt, rd);
    i.jump = 1'b1; i.wr_ra_jal = 1'b1; i.we_reg = 1'b1; i.jal_wd_sel = 1'b1;
    return i;
  endfunction

  // ---------------- behavioural model ----------------
  instr_t        cur;        // what the decode slot presents this cycle
  instr_t        m;          // what the EX slot must hold
  logic [RW-1:0] m_wa;
  int            m_cnt;
  bit            model_live = 1'b0;

  function automatic bit model_load_use();
    bit reads_rs, reads_rt;
    reads_rs = cur.valid && !cur.jump && (cur.rs == m_wa);
    reads_rt = cur.valid && (cur.r_type || cur.branch || cur.we_dm) && (cur.rt == m_wa);
    return m.valid && m.dm_load_op && m.we_reg && (m_wa != 0) && (reads_rs || reads_rt);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m = '0; m_wa = '0; m_cnt = 0; model_live = 1'b1;
    end else if (flush_e) begin
      m = '0; m_wa = '0;
    end else if (hold_e) begin
      // EX slot frozen
    end else if (model_load_use()) begin
      m = '0; m_wa = '0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m = cur;
      if (!cur.valid) begin m.we_reg = 1'b0; m.we_dm = 1'b0; end
      if (cur.jump && cur.wr_ra_jal) m_wa = 5'd31;
      else if (cur.r_type)           m_wa = cur.rd;
      else                           m_wa = cur.rt;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("stall_fd", stall_fd, (model_load_use() && !flush_e) || hold_e);
      check("valid_e", valid_e, m.valid);
      check("ctrl_e",
            {branch_e, jump_e, we_reg_e, alu_src_imm_e, we_dm_e, wr_ra_jal_e,
             wr_ra_instr_e, jal_wd_sel_e, dm_load_op_e, r_type_e, alu_op_e},
            {m.branch, m.jump, m.we_reg, m.alu_src_imm, m.we_dm, m.wr_ra_jal,
             m.wr_ra_instr, m.jal_wd_sel, m.dm_load_op, m.r_type, m.alu_op});
      check("pc_rd1_e", {pc_plus4_e, rd1_e}, {m.pc, m.rd1});
      check("rd2_imm_e", {rd2_e, imm_e}, {m.rd2, m.imm});
      check("rs_rt_wa_e", {rs_e, rt_e, wa_e}, {m.rs, m.rt, m_wa});
      check("bubble_cnt", bubble_cnt, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input instr_t i);
    cur           = i;
    valid_d       = i.valid;       branch_d     = i.branch;
    jump_d        = i.jump;        we_reg_d     = i.we_reg;
    alu_src_imm_d = i.alu_src_imm; we_dm_d      = i.we_dm;
    wr_ra_jal_d   = i.wr_ra_jal;   wr_ra_instr_d = i.wr_ra_instr;
    jal_wd_sel_d  = i.jal_wd_sel;  dm_load_op_d = i.dm_load_op;
    r_type_d      = i.r_type;      alu_op_d     = i.alu_op;
    pc_plus4_d    = i.pc;          rd1_d        = i.rd1;
    rd2_d         = i.rd2;         imm_d        = i.imm;
    rs_d          = i.rs;          rt_d         = i.rt;
    rd_d          = i.rd;
  endtask

  // Present one decode slot just after an edge; return mid-cycle, where the
  // outputs show the previous edge's result and stall_fd reflects these inputs.
  task automatic apply(input instr_t i, input bit rst, input bit fl, input bit hd);
    @(posedge clk);
    #1;
    drive(i);
    rst_n = rst; flush_e = fl; hold_e = hd;
    @(negedge clk);
  endtask

  instr_t ones, nop, held, inv;
  int     exp_sat [4] = '{1, 2, 3, 3};

  initial begin
    ones = '1;
    nop  = '0;

    // Reset with every input high
    drive(ones);
    rst_n = 1'b0; flush_e = 1'b1; hold_e = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_valid_e", valid_e, 1'b0);
    check("rst_we_reg_e", we_reg_e, 1'b0);
    check("rst_rd1_e", rd1_e, 32'h0);
    check("rst_wa_e", wa_e, 5'd0);
    check("rst_bubble_cnt", bubble_cnt, 2'd0);

    apply(mk_r(5'd1, 5'd2, 5'd3, ALU_ADD), 1'b1, 1'b0, 1'b0);
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("first_valid_e", valid_e, 1'b1);
    check("first_wa_e", wa_e, 5'd3);

    // Load-use on rs
    apply(mk_lw(5'd9, 5'd8), 1'b1, 1'b0, 1'b0);
    apply(mk_r(5'd8, 5'd2, 5'd10, ALU_ADD), 1'b1, 1'b0, 1'b0);
    check("lw_wa_e", wa_e, 5'd8);
    check("lu_stall", stall_fd, 1'b1);
    apply(mk_r(5'd8, 5'd2, 5'd10, ALU_ADD), 1'b1, 1'b0, 1'b0);
    check("lu_bubble_valid", valid_e, 1'b0);
    check("lu_bubble_cnt", bubble_cnt, 2'd1);
    check("lu_stall_released", stall_fd, 1'b0);
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("lu_add_captured", {valid_e, wa_e}, {1'b1, 5'd10});

    // Load to $0 never stalls
    apply(mk_lw(5'd9, 5'd0), 1'b1, 1'b0, 1'b0);
    apply(mk_r(5'd0, 5'd2, 5'd11, ALU_SLT), 1'b1, 1'b0, 1'b0);
    check("zero_reg_stall", stall_fd, 1'b0);
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("zero_reg_captured", {valid_e, wa_e, alu_op_e}, {1'b1, 5'd11, ALU_SLT});
    check("zero_reg_cnt", bubble_cnt, 2'd1);

    // Destination resolution
    apply(mk_jal(5'd4, 5'd7, 5'd5), 1'b1, 1'b0, 1'b0);
    apply(mk_r(5'd1, 5'd2, 5'd5, ALU_ADD), 1'b1, 1'b0, 1'b0);
    check("jal_wa_e", wa_e, 5'd31);
    apply(mk_addi(5'd1, 5'd7), 1'b1, 1'b0, 1'b0);
    check("rtype_wa_e", wa_e, 5'd5);
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("itype_wa_e", wa_e, 5'd7);

    // Flush together with a load-use hazard
    apply(mk_lw(5'd9, 5'd8), 1'b1, 1'b0, 1'b0);
    apply(mk_r(5'd8, 5'd2, 5'd10, ALU_ADD), 1'b1, 1'b1, 1'b0);
    check("flush_lu_stall", stall_fd, 1'b0);
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("flush_lu_bubble", {valid_e, rd1_e}, {1'b0, 32'h0});
    check("flush_lu_cnt", bubble_cnt, 2'd1);

    // Flush together with hold
    apply(mk_r(5'd1, 5'd2, 5'd12, ALU_ADD), 1'b1, 1'b0, 1'b0);
    apply(mk_r(5'd3, 5'd4, 5'd6, ALU_ADD), 1'b1, 1'b1, 1'b1);
    check("flush_hold_stall", stall_fd, 1'b1);
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("flush_hold_bubble", {valid_e, wa_e}, {1'b0, 5'd0});

    // Hold for three cycles with changing decode inputs
    held     = mk_r(5'd1, 5'd2, 5'd13, ALU_ADD);
    apply(held, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(mk_r(5'(k + 14), 5'(k + 20), 5'(k + 25), ALU_SLT), 1'b1, 1'b0, 1'b1);
      check("hold_stall", stall_fd, 1'b1);
      check("hold_rd1_e", {rd1_e, wa_e}, {32'h1000_0001, 5'd13});
    end
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("hold_release_rd1_e", {rd1_e, wa_e}, {32'h1000_0001, 5'd13});

    // Invalid decode slot still captures, with write enables dropped
    inv       = mk_sw(5'd3, 5'd4);
    inv.valid = 1'b0;
    inv.we_reg = 1'b1;
    apply(inv, 1'b1, 1'b0, 1'b0);
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("inv_valid_we", {valid_e, we_reg_e, we_dm_e}, 3'b000);
    check("inv_rd2_e", rd2_e, 32'h2000_0004);

    // Store data dependency (rt) stalls; jump does not read rs
    apply(mk_lw(5'd9, 5'd8), 1'b1, 1'b0, 1'b0);
    apply(mk_sw(5'd9, 5'd8), 1'b1, 1'b0, 1'b0);
    check("sw_rt_stall", stall_fd, 1'b1);
    apply(mk_sw(5'd9, 5'd8), 1'b1, 1'b0, 1'b0);
    apply(mk_lw(5'd9, 5'd8), 1'b1, 1'b0, 1'b0);
    apply(mk_jal(5'd8, 5'd3, 5'd5), 1'b1, 1'b0, 1'b0);
    check("jal_rs_no_stall", stall_fd, 1'b0);

    // Saturation of the 2-bit bubble counter
    apply(nop, 1'b0, 1'b0, 1'b0);
    apply(nop, 1'b1, 1'b0, 1'b0);
    check("sat_reset_cnt", bubble_cnt, 2'd0);
    for (int k = 0; k < 4; k++) begin
      apply(mk_lw(5'd9, 5'd8), 1'b1, 1'b0, 1'b0);
      apply(mk_r(5'd8, 5'd2, 5'd10, ALU_ADD), 1'b1, 1'b0, 1'b0);
      apply(mk_r(5'd8, 5'd2, 5'd10, ALU_ADD), 1'b1, 1'b0, 1'b0);
      check("sat_cnt", bubble_cnt, exp_sat[k]);
    end
    apply(nop, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
